// File: rtl/control_pulsos_pkg.sv
// rtl/control_pulsos_pkg.sv - FSM state encoding and width helpers for control_pulsos
package control_pulsos_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DELAY    = 2'd1;
    localparam logic [1:0] ST_REPEAT   = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/control_pulsos_if.sv
// rtl/control_pulsos_if.sv - button inputs and counter-control outputs of control_pulsos
interface control_pulsos_if;
    logic BTN_UP;
    logic BTN_DOWN;
    logic ENABLE;
    logic UP_DOWN;
    logic BUSY;

    modport master (output BTN_UP, BTN_DOWN, input ENABLE, UP_DOWN, BUSY);
    modport slave  (input BTN_UP, BTN_DOWN, output ENABLE, UP_DOWN, BUSY);
endinterface

// File: rtl/control_pulsos_antirrebote.sv
// rtl/control_pulsos_antirrebote.sv - 2-FF synchronizer and debounce counter for one button
module antirrebote
    import control_pulsos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int            CW       = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any agreement between synced and debounced restarts the run.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/control_pulsos.sv
// rtl/control_pulsos.sv - turns up/down push-buttons into counter ENABLE pulses and UP_DOWN direction
module control_pulsos
    import control_pulsos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int AUTOREPEAT      = 1
) (
    input  logic             CLK,
    input  logic             RST,
    control_pulsos_if.slave  bus
);

    localparam int            TW          = clog2_min1(max_of(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic          lvl_up, lvl_dn, prs_up, prs_dn;
    logic [1:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          enable_q, pulse_n;
    logic          up_down_q, up_down_n;
    logic          act_lvl, oth_lvl;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_up (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (bus.BTN_UP),
        .level (lvl_up),
        .press (prs_up)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_dn (
        .CLK   (CLK),
        .RST   (RST),
        .raw   (bus.BTN_DOWN),
        .level (lvl_dn),
        .press (prs_dn)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            timer     <= '0;
            enable_q  <= 1'b0;
            up_down_q <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            enable_q  <= pulse_n;
            up_down_q <= up_down_n;
        end
    end

    // up_down_q doubles as the identity of the held button outside IDLE.
    assign act_lvl = up_down_q ? lvl_up : lvl_dn;
    assign oth_lvl = up_down_q ? lvl_dn : lvl_up;

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        pulse_n   = 1'b0;
        up_down_n = up_down_q;
        case (state)
            ST_IDLE: begin
                if ((prs_up || prs_dn) && lvl_up && lvl_dn) begin
                    state_n = ST_WAIT_REL;
                end else if (prs_up) begin
                    pulse_n   = 1'b1;
                    up_down_n = 1'b1;
                    timer_n   = '0;
                    state_n   = ST_DELAY;
                end else if (prs_dn) begin
                    pulse_n   = 1'b1;
                    up_down_n = 1'b0;
                    timer_n   = '0;
                    state_n   = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!act_lvl) begin
                    state_n = ST_IDLE;
                end else if (oth_lvl) begin
                    state_n = ST_WAIT_REL;
                end else if (AUTOREPEAT == 0) begin
                    timer_n = timer;
                end else if (timer == DELAY_LAST) begin
                    pulse_n = 1'b1;
                    timer_n = '0;
                    state_n = ST_REPEAT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!act_lvl) begin
                    state_n = ST_IDLE;
                end else if (oth_lvl) begin
                    state_n = ST_WAIT_REL;
                end else if (timer == PERIOD_LAST) begin
                    pulse_n = 1'b1;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!lvl_up && !lvl_dn) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ENABLE  = enable_q;
        bus.UP_DOWN = up_down_q;
        bus.BUSY    = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_control_pulsos.sv
// tb/tb_control_pulsos.sv - self-checking bench for control_pulsos
module tb_control_pulsos;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    control_pulsos_if bus ();

    control_pulsos #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .AUTOREPEAT      (1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;
    int pulses[$];
    int pulse_dir[$];

    // Reference model: per button, synced sample age and run length; a hold is
    // tracked as cycles elapsed since the accepted press.
    int s1[2], s2[2], deb[2], run[2], rose[2];
    int m_mode = 0;      // 0 idle, 1 holding, 2 waiting for release
    int m_dir  = 1;
    int m_el   = 0;
    bit m_en   = 1'b0;
    bit m_ud   = 1'b1;
    bit prev_en = 1'b0;

    always @(posedge CLK) begin
        int raw[2];
        int act, oth;
        cyc++;
        raw[0] = int'(bus.BTN_UP);
        raw[1] = int'(bus.BTN_DOWN);
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                s1[b] = 0; s2[b] = 0; deb[b] = 0; run[b] = 0; rose[b] = 0;
            end
            m_mode = 0; m_el = 0; m_en = 1'b0; m_ud = 1'b1; m_dir = 1;
        end else begin
            m_en = 1'b0;
            if (m_mode == 0) begin
                if ((rose[0] != 0 || rose[1] != 0) && deb[0] != 0 && deb[1] != 0) begin
                    m_mode = 2;
                end else if (rose[0] != 0 || rose[1] != 0) begin
                    m_dir  = (rose[0] != 0) ? 1 : 0;
                    m_ud   = (m_dir == 1);
                    m_en   = 1'b1;
                    m_el   = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                act = (m_dir == 1) ? deb[0] : deb[1];
                oth = (m_dir == 1) ? deb[1] : deb[0];
                if (act == 0) m_mode = 0;
                else if (oth != 0) m_mode = 2;
                else begin
                    m_el++;
                    if (m_el == RD || (m_el > RD && (m_el - RD) % RP == 0)) m_en = 1'b1;
                end
            end else begin
                if (deb[0] == 0 && deb[1] == 0) m_mode = 0;
            end
            for (int b = 0; b < 2; b++) begin
                rose[b] = 0;
                if (s2[b] != deb[b]) begin
                    run[b]++;
                    if (run[b] == DC) begin
                        deb[b]  = s2[b];
                        run[b]  = 0;
                        rose[b] = deb[b];
                    end
                end else begin
                    run[b] = 0;
                end
                s2[b] = s1[b];
                s1[b] = raw[b];
            end
        end
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            checks++;
            assert (bus.ENABLE === m_en) else begin
                failures++;
                $error("FAIL enable cyc=%0d observed=%b expected=%b", cyc, bus.ENABLE, m_en);
            end
            checks++;
            assert (bus.UP_DOWN === m_ud) else begin
                failures++;
                $error("FAIL up_down cyc=%0d observed=%b expected=%b", cyc, bus.UP_DOWN, m_ud);
            end
            checks++;
            assert (bus.BUSY === (m_mode != 0)) else begin
                failures++;
                $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, bus.BUSY, (m_mode != 0));
            end
            checks++;
            assert (!(prev_en && bus.ENABLE === 1'b1)) else begin
                failures++;
                $error("FAIL back_to_back cyc=%0d observed=1 expected=0", cyc);
            end
            prev_en = (bus.ENABLE === 1'b1);
            if (bus.ENABLE === 1'b1) begin
                pulses.push_back(cyc - base);
                pulse_dir.push_back(int'(bus.UP_DOWN));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_scn();
        pulses.delete();
        pulse_dir.delete();
        base = cyc;
    endtask

    task automatic check_pulses(input string tag, input int exp_q[$]);
        check({tag, "_count"}, pulses.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_edge"}, (i < pulses.size()) ? pulses[i] : -1, exp_q[i]);
    endtask

    initial begin
        int r;
        int hold;
        bus.BTN_UP   = 1'b0;
        bus.BTN_DOWN = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_enable", bus.ENABLE, 0);
        check("reset_up_down", bus.UP_DOWN, 1);
        check("reset_busy", bus.BUSY, 0);
        RST = 1'b0;

        // Clean UP press held 10 cycles
        start_scn();
        bus.BTN_UP = 1'b1;
        repeat (10) @(negedge CLK);
        bus.BTN_UP = 1'b0;
        repeat (20) @(negedge CLK);
        check_pulses("single_press", '{7});
        check("single_press_dir", (pulse_dir.size() > 0) ? pulse_dir[0] : -1, 1);
        check("single_press_busy", bus.BUSY, 0);

        // DOWN glitches of 1, 2, 3 cycles
        start_scn();
        for (int w = 1; w <= 3; w++) begin
            bus.BTN_DOWN = 1'b1;
            repeat (w) @(negedge CLK);
            bus.BTN_DOWN = 1'b0;
            repeat (12) @(negedge CLK);
        end
        check("glitch_pulses", pulses.size(), 0);
        check("glitch_up_down", bus.UP_DOWN, 1);
        check("glitch_busy", bus.BUSY, 0);

        // UP held 60 cycles: auto-repeat
        start_scn();
        bus.BTN_UP = 1'b1;
        repeat (60) @(negedge CLK);
        bus.BTN_UP = 1'b0;
        repeat (20) @(negedge CLK);
        check_pulses("autorepeat", '{7, 27, 35, 43, 51, 59});
        check("autorepeat_busy", bus.BUSY, 0);

        // Simultaneous press, then a DOWN press
        start_scn();
        bus.BTN_UP = 1'b1;
        bus.BTN_DOWN = 1'b1;
        repeat (12) @(negedge CLK);
        check("both_pulses", pulses.size(), 0);
        check("both_wait_busy", bus.BUSY, 1);
        bus.BTN_UP = 1'b0;
        bus.BTN_DOWN = 1'b0;
        repeat (12) @(negedge CLK);
        check("both_released_busy", bus.BUSY, 0);
        start_scn();
        bus.BTN_DOWN = 1'b1;
        repeat (10) @(negedge CLK);
        bus.BTN_DOWN = 1'b0;
        repeat (12) @(negedge CLK);
        check_pulses("down_press", '{7});
        check("down_press_dir", (pulse_dir.size() > 0) ? pulse_dir[0] : -1, 0);
        check("down_up_down_level", bus.UP_DOWN, 0);

        // UP held, DOWN joins at edge 15
        start_scn();
        bus.BTN_UP = 1'b1;
        repeat (14) @(negedge CLK);
        bus.BTN_DOWN = 1'b1;
        repeat (26) @(negedge CLK);
        check_pulses("interrupt", '{7});
        check("interrupt_busy", bus.BUSY, 1);
        bus.BTN_DOWN = 1'b0;
        repeat (12) @(negedge CLK);
        check("interrupt_one_held_busy", bus.BUSY, 1);
        bus.BTN_UP = 1'b0;
        repeat (12) @(negedge CLK);
        check("interrupt_released_busy", bus.BUSY, 0);

        // Reset while DOWN is held in REPEAT
        start_scn();
        bus.BTN_DOWN = 1'b1;
        repeat (40) @(negedge CLK);
        check_pulses("pre_reset", '{7, 27, 35});
        RST = 1'b1;
        @(negedge CLK);
        check("mid_reset_enable", bus.ENABLE, 0);
        check("mid_reset_up_down", bus.UP_DOWN, 1);
        check("mid_reset_busy", bus.BUSY, 0);
        RST = 1'b0;
        start_scn();
        repeat (10) @(negedge CLK);
        check_pulses("post_reset", '{7});
        bus.BTN_DOWN = 1'b0;
        repeat (15) @(negedge CLK);

        // Random button activity against the reference model
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end else begin
                bus.BTN_UP   = ($urandom_range(0, 2) == 0);
                bus.BTN_DOWN = ($urandom_range(0, 2) == 0);
                hold = $urandom_range(1, 40);
                repeat (hold) @(negedge CLK);
            end
        end
        bus.BTN_UP   = 1'b0;
        bus.BTN_DOWN = 1'b0;
        repeat (20) @(negedge CLK);
        check("final_busy", bus.BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
